// File: rtl/serial_twos_complementer.sv
// Bit-serial two's-complement engine: NEG, ABS, SM2TC and TC2SM on a WIDTH-bit operand,
// processed CHUNK bits per clock (LSB chunk first) behind valid/ready handshakes.
module serial_twos_complementer #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] MODE_NEG   = 2'b00;
  localparam logic [1:0] MODE_ABS   = 2'b01;
  localparam logic [1:0] MODE_SM2TC = 2'b10;
  localparam logic [1:0] MODE_TC2SM = 2'b11;

  if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("serial_twos_complementer: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   operand_q;
  logic               negate_q;
  logic               tc2sm_q;
  logic               sign_q;
  logic               carry_q;
  logic [CNT_W-1:0]   count_q;

  logic [WIDTH-1:0]   operand_in;
  logic               negate_in;
  logic               ovf_in;
  int                 idx;
  logic [CHUNK-1:0]   op_chunk;
  logic [CHUNK:0]     sum_ext;
  logic [CHUNK-1:0]   res_chunk;
  logic [WIDTH-1:0]   z_next;

  // Accept-time decode: what gets negated and whether the result can overflow.
  always_comb begin
    operand_in = x;
    negate_in  = x[WIDTH-1];
    ovf_in     = (x == MIN);
    case (mode)
      MODE_NEG:   negate_in = 1'b1;
      MODE_ABS:   negate_in = x[WIDTH-1];
      MODE_SM2TC: begin
        operand_in = x & ~MIN;
        ovf_in     = 1'b0;
      end
      MODE_TC2SM: negate_in = x[WIDTH-1];
      default:    negate_in = x[WIDTH-1];
    endcase
  end

  // One CHUNK-wide increment of the inverted chunk; TC2SM re-imposes the sign on the last chunk.
  always_comb begin
    idx       = int'(count_q) * CHUNK;
    op_chunk  = operand_q[idx +: CHUNK];
    sum_ext   = {1'b0, ~op_chunk} + {{CHUNK{1'b0}}, carry_q};
    res_chunk = negate_q ? sum_ext[CHUNK-1:0] : op_chunk;
    z_next    = z;
    z_next[idx +: CHUNK] = res_chunk;
    if (tc2sm_q && (count_q == LAST)) begin
      z_next[WIDTH-1] = sign_q;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (count_q == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand_q <= '0;
      negate_q  <= 1'b0;
      tc2sm_q   <= 1'b0;
      sign_q    <= 1'b0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      z         <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            operand_q <= operand_in;
            negate_q  <= negate_in;
            tc2sm_q   <= (mode == MODE_TC2SM);
            sign_q    <= x[WIDTH-1];
            ovf       <= ovf_in;
            carry_q   <= 1'b1;
            count_q   <= '0;
          end
        end
        BUSY: begin
          z       <= z_next;
          carry_q <= negate_q ? sum_ext[CHUNK] : carry_q;
          count_q <= count_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
